// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle mul/div stall.
// Define MULDIV_STALL_EN to build the MULDIV_WAIT stall FSM; otherwise muldiv_start_i is ignored.
module hazard_ctrl #(
    parameter int REG_ADDR_BITS = 5,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_ADDR_BITS-1:0] id_rs_i,
    input  logic [REG_ADDR_BITS-1:0] id_rt_i,
    input  logic                     ex_mem_read_i,
    input  logic [REG_ADDR_BITS-1:0] ex_rt_i,
    input  logic                     branch_taken_i,
    input  logic                     muldiv_start_i,
    output logic                     pc_en_o,
    output logic                     if_id_en_o,
    output logic                     id_ex_en_o,
    output logic                     if_id_flush_o,
    output logic                     id_ex_flush_o,
    output logic                     ex_mem_flush_o,
    output logic                     busy_o,
    output logic [15:0]              stall_cycles_o
);

    typedef enum logic [0:0] {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // r0 is hardwired zero, so a load targeting it can never create a dependency.
    assign load_use = ex_mem_read_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

`ifdef MULDIV_STALL_EN
    logic [5:0] cnt_q, cnt_d;
    logic       unused_cfg;

    assign unused_cfg = 1'b0;
`else
    logic [6:0] unused_cfg;

    assign unused_cfg = {muldiv_start_i, CNT_LOAD};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
`ifdef MULDIV_STALL_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef MULDIV_STALL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        busy_o         = 1'b0;
`ifdef MULDIV_STALL_EN
        cnt_d          = cnt_q;
`endif

        if (!reset) begin
            state_d    = RUN;
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            id_ex_en_o = 1'b0;
`ifdef MULDIV_STALL_EN
            cnt_d      = '0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken_i) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
`ifdef MULDIV_STALL_EN
                    end else if (muldiv_start_i) begin
                        pc_en_o        = 1'b0;
                        if_id_en_o     = 1'b0;
                        id_ex_en_o     = 1'b0;
                        ex_mem_flush_o = 1'b1;
                        busy_o         = 1'b1;
                        cnt_d          = CNT_LOAD;
                        state_d        = MULDIV_WAIT;
`endif
                    end else if (load_use) begin
                        pc_en_o       = 1'b0;
                        if_id_en_o    = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
`ifdef MULDIV_STALL_EN
                MULDIV_WAIT: begin
                    // Start cycle plus CNT_LOAD wait cycles gives MULDIV_CYCLES stalled cycles.
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_flush_o = 1'b1;
                    busy_o         = 1'b1;
                    cnt_d          = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = RUN;
                    end
                end
`endif
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule
